sequence_encoder: RTL and testbench

- Timing sequence counter; the encoding end of the timing-signal path.
- Holds the binary step code that the downstream 4-to-16 timing decoder expands into one-hot T0..T15.
- Supports increment, clear, and a jump load from a one-hot vector, which is priority-encoded back to binary.
- Flags malformed one-hot jump requests with a sticky error bit.

---
 rtl/sequence_encoder.sv | 71 +++++++
 tb/tb_sequence_encoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sequence_encoder.sv
// Timing-sequence step counter: holds the binary code that the 4-to-16 timing
// decoder expands, with increment, clear, and a priority-encoded one-hot jump.
module sequence_encoder #(
   parameter int WIDTH      = 4,
   parameter int RESET_CODE = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inr,
   input  logic                  clr,
   input  logic                  load,
   input  logic [2**WIDTH-1:0]   jump,
   input  logic                  clr_err,
   output logic [WIDTH-1:0]      code,
   output logic                  wrap,
   output logic                  onehot_err
);

   localparam int N = 2**WIDTH;
   localparam logic [WIDTH-1:0] RST_CODE = WIDTH'(RESET_CODE);
   localparam logic [N-1:0]     ONE_N    = N'(1);

   logic [WIDTH-1:0] enc_idx;
   logic             jump_any;
   logic             jump_onehot;
   logic             bad_load;

   // Highest set bit wins, so a malformed vector still selects a defined step.
   always_comb begin
      enc_idx  = '0;
      jump_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (jump[i]) begin
            enc_idx  = i[WIDTH-1:0];
            jump_any = 1'b1;
         end
      end
   end

   assign jump_onehot = jump_any && ((jump & (jump - ONE_N)) == '0);
   assign bad_load    = load && !clr && !jump_onehot;

   always_ff @(posedge clk) begin
      if (reset) begin
         code <= RST_CODE;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clr) begin
            code <= RST_CODE;
         end else if (load) begin
            if (jump_any) code <= enc_idx;
         end else if (inr) begin
            code <= code + WIDTH'(1);
            wrap <= &code;
         end
      end
   end

   // A malformed load in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         onehot_err <= 1'b0;
      end else if (bad_load) begin
         onehot_err <= 1'b1;
      end else if (clr_err) begin
         onehot_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sequence_encoder.sv
// Bench for sequence_encoder: directed scenarios with literal expectations plus
// randomized commands compared every cycle against a behavioural model.
module tb_sequence_encoder;

   localparam int W  = 4;
   localparam int N  = 16;
   localparam int RC = 0;

   logic         clk = 1'b0;
   logic         reset, inr, clr, load, clr_err;
   logic [N-1:0] jump;
   logic [W-1:0] code;
   logic         wrap, onehot_err;

   int checks = 0;
   int errors = 0;

   // model state
   int m_code = 0;
   bit m_wrap = 0;
   bit m_err  = 0;
   bit m_valid = 0;

   sequence_encoder #(.WIDTH(W), .RESET_CODE(RC)) dut (
      .clk(clk), .reset(reset), .inr(inr), .clr(clr), .load(load),
      .jump(jump), .clr_err(clr_err), .code(code), .wrap(wrap),
      .onehot_err(onehot_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: step semantics straight from the command rules
   always @(posedge clk) begin
      if (reset) begin
         m_code = RC; m_wrap = 0; m_err = 0; m_valid = 1;
      end else begin
         int hi;
         bit bad;
         hi  = -1;
         bad = 0;
         m_wrap = 0;
         if (clr) begin
            m_code = RC;
         end else if (load) begin
            for (int b = 0; b < N; b++) if (jump[b]) hi = b;
            bad = ($countones(jump) != 1);
            if (hi >= 0) m_code = hi;
         end else if (inr) begin
            m_wrap = (m_code == N - 1);
            m_code = (m_code + 1) % N;
         end
         if (bad) m_err = 1;
         else if (clr_err) m_err = 0;
      end
   end

   // compare process
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_code", int'(code), m_code);
         chk("model_wrap", int'(wrap), int'(m_wrap));
         chk("model_err", int'(onehot_err), int'(m_err));
      end
   end

   // drive one cycle of inputs, return just after the edge that consumes them
   task automatic cyc(input bit r, input bit i, input bit c, input bit l,
                      input logic [N-1:0] j, input bit ce);
      @(negedge clk);
      reset = r; inr = i; clr = c; load = l; jump = j; clr_err = ce;
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input int ec, input int ew, input int ee);
      chk({name, "_code"}, int'(code), ec);
      chk({name, "_wrap"}, int'(wrap), ew);
      chk({name, "_err"}, int'(onehot_err), ee);
   endtask

   initial begin
      reset = 1; inr = 0; clr = 0; load = 0; jump = '0; clr_err = 0;
      cyc(1, 0, 0, 0, '0, 0);
      cyc(1, 1, 1, 1, 16'h0003, 0);
      lit("reset", 0, 0, 0);

      // count through rollover
      for (int k = 1; k <= 17; k++) begin
         cyc(0, 1, 0, 0, '0, 0);
         lit("count", k % 16, (k == 16) ? 1 : 0, 0);
      end

      // clr beats load and inr
      cyc(1, 0, 0, 0, '0, 0);
      for (int k = 0; k < 9; k++) cyc(0, 1, 0, 0, '0, 0);
      lit("count9", 9, 0, 0);
      cyc(0, 1, 1, 1, 16'h0080, 0);
      lit("clr_prio", 0, 0, 0);
      cyc(0, 1, 0, 0, '0, 0);
      lit("after_clr", 1, 0, 0);

      // valid jump
      cyc(1, 0, 0, 0, '0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, '0, 0);
      cyc(0, 1, 0, 1, 16'h0400, 0);
      lit("jump10", 10, 0, 0);
      cyc(0, 1, 0, 0, '0, 0);
      lit("inc11", 11, 0, 0);

      // malformed jumps
      cyc(0, 0, 0, 1, 16'h0A00, 0);
      lit("multi", 11, 0, 1);
      cyc(0, 1, 0, 1, 16'h0000, 0);
      lit("zero", 11, 0, 1);
      cyc(0, 0, 0, 0, '0, 1);
      lit("clr_err", 11, 0, 0);
      cyc(0, 0, 0, 1, 16'h0003, 1);
      lit("set_wins", 1, 0, 1);
      cyc(0, 0, 1, 0, '0, 0);
      lit("clr_keeps_err", 0, 0, 1);

      // reset at code 15 with increment pending
      for (int k = 0; k < 15; k++) cyc(0, 1, 0, 0, '0, 0);
      lit("at15", 15, 0, 1);
      cyc(1, 1, 0, 0, '0, 0);
      lit("reset15", 0, 0, 0);

      // random commands
      for (int k = 0; k < 3000; k++) begin
         logic [N-1:0] j;
         case ($urandom_range(0, 3))
            0, 1: j = N'(1) << $urandom_range(0, N - 1);
            2: j = N'($urandom);
            default: j = '0;
         endcase
         cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70,
             $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 15, j,
             $urandom_range(0, 99) < 10);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
